// File: rtl/wasm_top.sv
// Byte-serial WebAssembly subset interpreter: one instruction byte per clock,
// 32-bit operand stack, block/loop control stack, sticky status flags that halt the core.

module wasm_instr_mem #(
    parameter int AW = 10
) (
    input  logic [AW-1:0] addr,
    output logic [7:0]    rdata
);
    // Preloaded externally; the core only reads it.
    logic [7:0] bram [0:2**AW-1];

    assign rdata = bram[addr];
endmodule

module wasm_top #(
    parameter int INSTR_LOG2_BRAM_DEPTH = 10,
    parameter int STACK_DEPTH           = 16,
    parameter int CTRL_DEPTH            = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_INSTR_ERROR,
    output logic o_stack_exceed,
    output logic o_stack_empty_pop,
    output logic o_instr_finish
);
    localparam int AW  = INSTR_LOG2_BRAM_DEPTH;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int CPW = $clog2(CTRL_DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [CPW-1:0] CS_FULL = CPW'(CTRL_DEPTH);
    localparam logic [AW-1:0]  PC_LAST = '1;

    typedef enum logic [2:0] {
        S_EXEC, S_BLKTYPE, S_LEB, S_SKIP, S_SKIP_BT, S_SKIP_LEB
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   pc, pc_nxt;
    logic [SPW-1:0]  sp, sp_nxt;
    logic [CPW-1:0]  csp, csp_nxt, tgt;
    logic [7:0]      op, op_nxt, byte_in;
    logic [31:0]     leb_acc, leb_acc_nxt, leb_full, leb_val;
    logic [2:0]      leb_cnt, leb_cnt_nxt;
    logic [5:0]      leb_sh;
    logic [15:0]     skip_depth, skip_nxt;
    logic            err, exc, emp, fin;
    logic            err_nxt, exc_nxt, emp_nxt, fin_nxt, halted;

    logic signed [31:0] stack_mem [0:2**SPW-1];
    logic               ctrl_kind [0:2**CPW-1];
    logic [AW-1:0]      ctrl_start [0:2**CPW-1];
    logic signed [31:0] top_a, top_b, st_wdata;
    logic               st_we, cs_we, cs_wkind;
    logic [SPW-1:0]     st_waddr;
    logic [CPW-1:0]     cs_waddr;
    logic [AW-1:0]      cs_wstart;

    wasm_instr_mem #(.AW(AW)) u_instr_mem_ctrl (
        .addr  (pc),
        .rdata (byte_in)
    );

    function automatic logic signed [31:0] alu(input logic [7:0] opc,
                                               input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        case (opc)
            8'h46:   alu = {31'b0, a == b};
            8'h47:   alu = {31'b0, a != b};
            8'h48:   alu = {31'b0, a < b};
            8'h6A:   alu = a + b;
            8'h6B:   alu = a - b;
            8'h71:   alu = a & b;
            8'h72:   alu = a | b;
            8'h73:   alu = a ^ b;
            default: alu = '0;
        endcase
    endfunction

    assign halted = err | exc | emp | fin;
    assign top_b  = stack_mem[sp - SPW'(1)];
    assign top_a  = stack_mem[sp - SPW'(2)];

    // LEB128 accumulation; sign extension only applies below 32 accumulated bits.
    assign leb_sh   = {3'b000, leb_cnt} * 6'd7;
    assign leb_full = leb_acc | (32'(byte_in[6:0]) << leb_sh);
    assign leb_val  = (leb_cnt != 3'd4 && byte_in[6]) ? (leb_full | (32'hFFFF_FFFF << (leb_sh + 6'd7)))
                                                      : leb_full;
    assign tgt      = csp - CPW'(1) - leb_full[CPW-1:0];

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        sp_nxt      = sp;
        csp_nxt     = csp;
        op_nxt      = op;
        leb_acc_nxt = leb_acc;
        leb_cnt_nxt = leb_cnt;
        skip_nxt    = skip_depth;
        err_nxt     = err;
        exc_nxt     = exc;
        emp_nxt     = emp;
        fin_nxt     = fin;
        st_we       = 1'b0;
        st_waddr    = sp;
        st_wdata    = '0;
        cs_we       = 1'b0;
        cs_waddr    = csp;
        cs_wkind    = 1'b0;
        cs_wstart   = '0;
        if (!halted) begin
            if (pc == PC_LAST) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt = pc + 1'b1;
                case (state)
                    S_EXEC: begin
                        case (byte_in)
                            8'h01: ;
                            8'h02, 8'h03: begin
                                op_nxt    = byte_in;
                                state_nxt = S_BLKTYPE;
                            end
                            8'h0B: begin
                                if (csp == '0) fin_nxt = 1'b1;
                                else           csp_nxt = csp - 1'b1;
                            end
                            8'h0C, 8'h0D, 8'h41: begin
                                op_nxt      = byte_in;
                                leb_acc_nxt = '0;
                                leb_cnt_nxt = '0;
                                state_nxt   = S_LEB;
                            end
                            8'h0F: fin_nxt = 1'b1;
                            8'h1A: begin
                                if (sp == '0) emp_nxt = 1'b1;
                                else          sp_nxt  = sp - 1'b1;
                            end
                            8'h45: begin
                                if (sp == '0) emp_nxt = 1'b1;
                                else begin
                                    st_we    = 1'b1;
                                    st_waddr = sp - SPW'(1);
                                    st_wdata = {31'b0, top_b == '0};
                                end
                            end
                            8'h46, 8'h47, 8'h48, 8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: begin
                                if (sp < SPW'(2)) emp_nxt = 1'b1;
                                else begin
                                    st_we    = 1'b1;
                                    st_waddr = sp - SPW'(2);
                                    st_wdata = alu(byte_in, top_a, top_b);
                                    sp_nxt   = sp - 1'b1;
                                end
                            end
                            default: err_nxt = 1'b1;
                        endcase
                    end
                    S_BLKTYPE: begin
                        if (byte_in != 8'h40 || csp == CS_FULL) err_nxt = 1'b1;
                        else begin
                            cs_we     = 1'b1;
                            cs_wkind  = op[0];
                            cs_wstart = pc + 1'b1;
                            csp_nxt   = csp + 1'b1;
                            state_nxt = S_EXEC;
                        end
                    end
                    S_LEB: begin
                        leb_acc_nxt = leb_full;
                        if (byte_in[7]) begin
                            if (leb_cnt == 3'd4) err_nxt     = 1'b1;
                            else                 leb_cnt_nxt = leb_cnt + 1'b1;
                        end else begin
                            state_nxt = S_EXEC;
                            if (op == 8'h41) begin
                                if (sp == SP_FULL) exc_nxt = 1'b1;
                                else begin
                                    st_we    = 1'b1;
                                    st_wdata = leb_val;
                                    sp_nxt   = sp + 1'b1;
                                end
                            end else if (op == 8'h0D && sp == '0) begin
                                emp_nxt = 1'b1;
                            end else begin
                                if (op == 8'h0D) sp_nxt = sp - 1'b1;
                                if (op == 8'h0C || top_b != '0) begin
                                    if (leb_full >= 32'(csp)) begin
                                        err_nxt = 1'b1;
                                    end else if (ctrl_kind[tgt]) begin
                                        csp_nxt = tgt + 1'b1;
                                        pc_nxt  = ctrl_start[tgt];
                                    end else begin
                                        // Target block and everything inside it are popped; scan to its end.
                                        csp_nxt   = tgt;
                                        skip_nxt  = leb_full[15:0] + 16'd1;
                                        state_nxt = S_SKIP;
                                    end
                                end
                            end
                        end
                    end
                    S_SKIP: begin
                        case (byte_in)
                            8'h02, 8'h03: begin
                                skip_nxt  = skip_depth + 16'd1;
                                state_nxt = S_SKIP_BT;
                            end
                            8'h0B: begin
                                skip_nxt = skip_depth - 16'd1;
                                if (skip_depth == 16'd1) state_nxt = S_EXEC;
                            end
                            8'h0C, 8'h0D, 8'h41: state_nxt = S_SKIP_LEB;
                            default: ;
                        endcase
                    end
                    S_SKIP_BT:  state_nxt = S_SKIP;
                    S_SKIP_LEB: if (!byte_in[7]) state_nxt = S_SKIP;
                    default:    state_nxt = S_EXEC;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state      <= S_EXEC;
            pc         <= '0;
            sp         <= '0;
            csp        <= '0;
            leb_cnt    <= '0;
            skip_depth <= '0;
            err        <= 1'b0;
            exc        <= 1'b0;
            emp        <= 1'b0;
            fin        <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            sp         <= sp_nxt;
            csp        <= csp_nxt;
            leb_cnt    <= leb_cnt_nxt;
            skip_depth <= skip_nxt;
            err        <= err_nxt;
            exc        <= exc_nxt;
            emp        <= emp_nxt;
            fin        <= fin_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        op      <= op_nxt;
        leb_acc <= leb_acc_nxt;
        if (st_we) stack_mem[st_waddr] <= st_wdata;
        if (cs_we) begin
            ctrl_kind[cs_waddr]  <= cs_wkind;
            ctrl_start[cs_waddr] <= cs_wstart;
        end
    end

    assign o_INSTR_ERROR     = err;
    assign o_stack_exceed    = exc;
    assign o_stack_empty_pop = emp;
    assign o_instr_finish    = fin;
endmodule

// File: tb/tb_wasm_top.sv
// Directed bench for wasm_top: hand-assembled programs with hand-computed flags and cycle counts.

module tb_wasm_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err, exc, emp, fin;
    logic [3:0] flags;
    int tests = 0;
    int fails = 0;
    int n;
    logic [7:0] prog [$];

    wasm_top dut (
        .i_clk             (clk),
        .i_rst_n           (rst),
        .o_INSTR_ERROR     (err),
        .o_stack_exceed    (exc),
        .o_stack_empty_pop (emp),
        .o_instr_finish    (fin)
    );

    always #5 clk = ~clk;

    assign flags = {err, exc, emp, fin};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_start(input logic [7:0] fill);
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) dut.u_instr_mem_ctrl.bram[i] = fill;
        foreach (prog[i]) dut.u_instr_mem_ctrl.bram[i] = prog[i];
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int max, output int cnt);
        cnt = 0;
        while (cnt < max && flags == 4'b0000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    // flags order: {INSTR_ERROR, stack_exceed, stack_empty_pop, instr_finish}
    task automatic exec(input string tag, input logic [7:0] fill, input int max,
                        input logic [3:0] exp_flags, input int exp_n);
        int c;
        load_start(fill);
        run(max, c);
        check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
        check({tag, "_cycles"}, c, exp_n);
    endtask

    initial begin
        #1;
        check("reset_state", 32'(flags), 32'h0);

        prog = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h1A, 8'h0B};
        exec("basic", 8'h00, 20, 4'b0001, 7);

        // Reset asserted right after finishing clears the outputs asynchronously.
        rst = 1'b1;
        #1;
        check("rst_clears_finish", 32'(flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run(20, n);
        check("rerun_flags", 32'(flags), 32'(4'b0001));
        check("rerun_cycles", n, 7);

        // Reset in the middle of the program restarts from pc=0.
        load_start(8'h00);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run(20, n);
        check("midrun_rerun_flags", 32'(flags), 32'(4'b0001));
        check("midrun_rerun_cycles", n, 7);

        prog = '{8'h02, 8'h40, 8'h02, 8'h40, 8'h41, 8'h01, 8'h0D, 8'h01, 8'h00,
                 8'h0B, 8'h00, 8'h0B, 8'h0B};
        exec("brif_outer", 8'h00, 40, 4'b0001, 13);

        prog = '{8'h03, 8'h40, 8'h41, 8'h00, 8'h0D, 8'h00, 8'h0B, 8'h0B};
        exec("loop_fall", 8'h00, 40, 4'b0001, 8);

        prog = '{8'h03, 8'h40, 8'h41, 8'h01, 8'h0D, 8'h00, 8'h0B, 8'h0B};
        exec("loop_inf", 8'h00, 500, 4'b0000, 500);

        prog = '{8'h6A};
        exec("pop_empty", 8'h00, 10, 4'b0010, 1);

        prog = '{8'hFF};
        exec("bad_opcode", 8'h00, 10, 4'b1000, 1);

        prog = {};
        for (int i = 0; i < 17; i++) begin
            prog.push_back(8'h41);
            prog.push_back(8'h01);
        end
        exec("push17", 8'h00, 100, 4'b0100, 34);
        repeat (5) @(posedge clk);
        #1;
        check("push17_halted", 32'(flags), 32'(4'b0100));

        prog = {};
        for (int i = 0; i < 9; i++) begin
            prog.push_back(8'h02);
            prog.push_back(8'h40);
        end
        exec("ctrl_overflow", 8'h00, 50, 4'b1000, 18);

        prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        exec("leb_too_long", 8'h00, 20, 4'b1000, 6);

        prog = '{8'h0C, 8'h00};
        exec("br_no_label", 8'h00, 10, 4'b1000, 2);

        prog = '{8'h02, 8'h41};
        exec("bad_blocktype", 8'h00, 10, 4'b1000, 2);

        prog = '{8'h02, 8'h40, 8'h0F};
        exec("return", 8'h00, 10, 4'b0001, 3);

        prog = {};
        exec("end_of_mem", 8'h01, 1100, 4'b1000, 1024);

        // Skip scan must step over nested blocks and LEB immediates (41 0B is not an end).
        prog = '{8'h02, 8'h40, 8'h0C, 8'h00, 8'h02, 8'h40, 8'h41, 8'h0B, 8'h0D, 8'h00,
                 8'h0B, 8'h00, 8'h0B, 8'h0B};
        exec("skip_nested", 8'h00, 40, 4'b0001, 14);

        // Arithmetic checks: the computed condition must be 1 to branch past an unreachable.
        prog = '{8'h02, 8'h40, 8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h41, 8'h08, 8'h46,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("add", 8'h00, 40, 4'b0001, 15);

        prog = '{8'h02, 8'h40, 8'h41, 8'h00, 8'h41, 8'h01, 8'h6B, 8'h41, 8'h7F, 8'h46,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("sub_wrap", 8'h00, 40, 4'b0001, 15);

        prog = '{8'h02, 8'h40, 8'h41, 8'h7F, 8'h41, 8'h00, 8'h48,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("lt_s", 8'h00, 40, 4'b0001, 12);

        prog = '{8'h02, 8'h40, 8'h41, 8'h0C, 8'h41, 8'h0A, 8'h71, 8'h41, 8'h08, 8'h46,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("and", 8'h00, 40, 4'b0001, 15);

        prog = '{8'h02, 8'h40, 8'h41, 8'h0C, 8'h41, 8'h0A, 8'h72, 8'h41, 8'h0E, 8'h46,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("or", 8'h00, 40, 4'b0001, 15);

        prog = '{8'h02, 8'h40, 8'h41, 8'h0C, 8'h41, 8'h0A, 8'h73, 8'h41, 8'h06, 8'h46,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("xor", 8'h00, 40, 4'b0001, 15);

        prog = '{8'h02, 8'h40, 8'h41, 8'h01, 8'h41, 8'h02, 8'h47,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("ne", 8'h00, 40, 4'b0001, 12);

        prog = '{8'h02, 8'h40, 8'h41, 8'h00, 8'h45, 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("eqz", 8'h00, 40, 4'b0001, 10);

        prog = '{8'h02, 8'h40, 8'h41, 8'h80, 8'h01, 8'h41, 8'hFF, 8'h00, 8'h6B, 8'h41, 8'h01,
                 8'h46, 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("leb_multi", 8'h00, 40, 4'b0001, 17);

        prog = '{8'h02, 8'h40, 8'h41, 8'h80, 8'h7F, 8'h41, 8'h80, 8'h01, 8'h6A, 8'h45,
                 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("leb_neg", 8'h00, 40, 4'b0001, 15);

        prog = '{8'h02, 8'h40, 8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h41, 8'h01, 8'h6A,
                 8'h41, 8'h00, 8'h48, 8'h0D, 8'h00, 8'h00, 8'h0B, 8'h0B};
        exec("leb_5byte_wrap", 8'h00, 40, 4'b0001, 19);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wasm_top.md
WASM_TOP -- requirements
Module: wasm_top

Interface
REQ-001 Parameter INSTR_LOG2_BRAM_DEPTH, default 10, log2 of instruction memory depth in bytes.
REQ-002 Parameter STACK_DEPTH, default 16, operand stack entries of 32 bits.
REQ-003 Parameter CTRL_DEPTH, default 8, control (block/loop) stack entries.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  reset; asynchronous, active-high, despite the port name.
REQ-006 o_INSTR_ERROR  output  1  sticky: undefined opcode, unreachable, or control-stack overflow/underflow.
REQ-007 o_stack_exceed  output  1  sticky: push attempted with operand stack full.
REQ-008 o_stack_empty_pop  output  1  sticky: pop attempted with too few operands.
REQ-009 o_instr_finish  output  1  sticky: program completed normally.
REQ-010 Instruction memory SHALL be instance u_instr_mem_ctrl with byte array bram[0:2**INSTR_LOG2_BRAM_DEPTH-1], preloadable by $readmemh, one byte per entry; the core never writes it.

Function
REQ-011 Core SHALL fetch one byte per cycle from pc (combinational read), starting at pc=0 after reset.
REQ-012 Supported opcodes SHALL be: 00 unreachable, 01 nop, 02 block, 03 loop, 0B end, 0C br L, 0D br_if L, 0F return, 1A drop, 41 i32.const, 45 i32.eqz, 46 i32.eq, 47 i32.ne, 48 i32.lt_s, 6A i32.add, 6B i32.sub, 71 i32.and, 72 i32.or, 73 i32.xor; any other byte SHALL set o_INSTR_ERROR.
REQ-013 block/loop SHALL consume a blocktype byte (must be 40, else o_INSTR_ERROR) and push a control entry {kind, loop start pc}.
REQ-014 Immediates (const value, label L) SHALL be signed/unsigned LEB128, at most 5 bytes, each byte one cycle; a 6th continuation byte SHALL set o_INSTR_ERROR.
REQ-015 i32.const SHALL push the sign-extended 32-bit value; arithmetic wraps modulo 2^32; comparisons push 1 or 0; binary ops pop b (top) then a, push a op b.
REQ-016 br L SHALL target control entry L (0 = innermost); L >= current control depth SHALL set o_INSTR_ERROR.
REQ-017 Branch to a loop SHALL pop entries above the target, keep the target, and set pc to the loop start (byte after blocktype).
REQ-018 Branch to a block SHALL enter SKIP state: scan forward byte-by-byte, count nesting on 02/03 (skipping blocktype) and 0B, skip LEB immediates of 41/0C/0D, and resume after the 0B closing the target, with L+1 entries popped.
REQ-019 br_if SHALL pop the condition; nonzero branches as br, zero continues.
REQ-020 end SHALL pop one control entry; end at control depth 0, or return, SHALL set o_instr_finish.
REQ-021 pc reaching the last memory address without finishing SHALL set o_INSTR_ERROR.
REQ-022 Operand stack push at STACK_DEPTH entries SHALL set o_stack_exceed and leave the stack unchanged; pop with insufficient entries SHALL set o_stack_empty_pop.
REQ-023 Control stack push at CTRL_DEPTH SHALL set o_INSTR_ERROR.
REQ-024 Any status flag set SHALL halt the core (pc, stacks frozen); flags stay high until reset; multiple flags may be set in the same cycle.
REQ-025 Operand stack values are not part of branch semantics (no block results); stack height is not adjusted on branch.

Reset
REQ-026 Reset assertion SHALL immediately clear all four outputs, pc, operand and control stack pointers; memory contents are preserved; reset mid-program restarts execution at pc=0 after release.

Verification
REQ-027 Program 41 05 41 03 6A 1A 0B -> o_instr_finish=1 within 10 cycles of reset release, all error flags 0.
REQ-028 Program 02 40 02 40 41 01 0D 01 00 0B 00 0B 0B -> br_if 1 skips both unreachables; o_instr_finish=1, o_INSTR_ERROR=0.
REQ-029 Program 03 40 41 00 0D 00 0B 0B -> loop falls through, finish=1; with 41 01 instead of 41 00 -> no finish within 500 cycles, no flags.
REQ-030 Program 6A -> o_stack_empty_pop=1 next cycle, finish stays 0; program FF -> o_INSTR_ERROR=1.
REQ-031 Program of 17 consecutive 41 01 -> o_stack_exceed=1 at the 17th push, core halted.
REQ-032 Assert reset mid-run of REQ-027 program -> outputs 0 immediately, program reruns and finishes again.
